// File: rtl/branch_resolve_unit.sv
// Carries D-stage branches through E and M, checks the prediction at M and drives flush/redirect.
// Redirect is held with stall_req until fetch accepts it; counters saturate at all-ones.
module branch_resolve_unit #(
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_stall,
  input  logic             branchD,
  input  logic             pred_takeD,
  input  logic [31:0]      pcD,
  input  logic [31:0]      targetD,
  input  logic             actual_takeE,
  input  logic             redirect_ready,
  output logic             branchM,
  output logic             actual_takeM,
  output logic [31:0]      pcM,
  output logic             errorM,
  output logic             flushD,
  output logic             flushE,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             stall_req,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [31:0] FT_INC = (DELAY_SLOT != 0) ? 32'd8 : 32'd4;

  typedef enum logic {NORMAL, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic        load_redirect;
  logic        advance;

  logic        valid_e, pred_e;
  logic [31:0] pc_e, target_e, fall_e;

  logic        valid_m, pred_m, take_m, reported;
  logic [31:0] pc_m, target_m, fall_m;

  assign advance = ~pipe_stall & ~stall_req;

  // A held M entry is reported once; the reported bit hides it on later stalled cycles.
  assign branchM      = valid_m & ~reported;
  assign errorM       = valid_m & ~reported & (pred_m != take_m);
  assign actual_takeM = take_m & valid_m;
  assign pcM          = pc_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_e  <= 1'b0;
      pred_e   <= 1'b0;
      pc_e     <= '0;
      target_e <= '0;
      fall_e   <= '0;
    end else begin
      if (advance) begin
        pred_e   <= pred_takeD;
        pc_e     <= pcD;
        target_e <= targetD;
        fall_e   <= pcD + FT_INC;
      end
      // The flush kills E even when the pipe is stalled.
      if (flushE)
        valid_e <= 1'b0;
      else if (advance)
        valid_e <= branchD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_m  <= 1'b0;
      pred_m   <= 1'b0;
      take_m   <= 1'b0;
      pc_m     <= '0;
      target_m <= '0;
      fall_m   <= '0;
      reported <= 1'b0;
    end else if (advance) begin
      valid_m  <= valid_e & ~flushE;
      pred_m   <= pred_e;
      take_m   <= actual_takeE;
      pc_m     <= pc_e;
      target_m <= target_e;
      fall_m   <= fall_e;
      reported <= 1'b0;
    end else if (valid_m) begin
      reported <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= NORMAL;
      redirect_pc <= '0;
    end else begin
      state <= state_nxt;
      if (load_redirect)
        redirect_pc <= take_m ? target_m : fall_m;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_redirect  = 1'b0;
    flushD         = 1'b0;
    flushE         = 1'b0;
    redirect_valid = 1'b0;
    stall_req      = 1'b0;
    case (state)
      NORMAL: begin
        if (errorM) begin
          flushD        = 1'b1;
          flushE        = 1'b1;
          load_redirect = 1'b1;
          state_nxt     = REDIRECT;
        end
      end
      REDIRECT: begin
        flushD         = 1'b1;
        flushE         = 1'b1;
        redirect_valid = 1'b1;
        stall_req      = 1'b1;
        if (redirect_ready)
          state_nxt = NORMAL;
      end
      default: state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (branchM && branch_cnt != {CNT_W{1'b1}})
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (errorM && mispred_cnt != {CNT_W{1'b1}})
        mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; small counters so saturation is reachable.
module tb_branch_resolve_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pipe_stall = 1'b0;
  logic          branchD = 1'b0;
  logic          pred_takeD = 1'b0;
  logic [31:0]   pcD = '0;
  logic [31:0]   targetD = '0;
  logic          actual_takeE = 1'b0;
  logic          redirect_ready = 1'b1;
  logic          branchM, actual_takeM, errorM, flushD, flushE;
  logic          redirect_valid, stall_req;
  logic [31:0]   pcM, redirect_pc;
  logic [CW-1:0] branch_cnt, mispred_cnt;
  logic [6:0]    flags;

  int n_cmp = 0;
  int n_err = 0;

  branch_resolve_unit #(.DELAY_SLOT(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pipe_stall(pipe_stall), .branchD(branchD),
    .pred_takeD(pred_takeD), .pcD(pcD), .targetD(targetD),
    .actual_takeE(actual_takeE), .redirect_ready(redirect_ready),
    .branchM(branchM), .actual_takeM(actual_takeM), .pcM(pcM), .errorM(errorM),
    .flushD(flushD), .flushE(flushE), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_req(stall_req),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  // {branchM, actual_takeM, errorM, flushD, flushE, redirect_valid, stall_req}
  assign flags = {branchM, actual_takeM, errorM, flushD, flushE, redirect_valid, stall_req};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branchD = 1'b0; pred_takeD = 1'b0; pcD = '0; targetD = '0;
    actual_takeE = 1'b0; pipe_stall = 1'b0; redirect_ready = 1'b1;
  endtask

  task automatic send(input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
    branchD = 1'b1; pred_takeD = pred; pcD = pc; targetD = tgt;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (flags !== 7'b0 || pcM !== 32'h0 || redirect_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: flags=%b pcM=%h rpc=%h want 0", flags, pcM, redirect_pc);
    end
    n_cmp++;
    if (branch_cnt !== 4'h0 || mispred_cnt !== 4'h0) begin
      n_err++;
      $display("FAIL reset_counters: bc=%0d mc=%0d want 0/0", branch_cnt, mispred_cnt);
    end
  endtask

  task automatic test_correct_taken();
    do_reset();
    send(1'b1, 32'h100, 32'h200);
    step();
    idle(); actual_takeE = 1'b1;
    n_cmp++;
    if (flags !== 7'b0) begin
      n_err++; $display("FAIL ct_empty_m: flags=%b want 0000000", flags);
    end
    step();
    idle();
    n_cmp++;
    if (flags !== 7'b1100000 || pcM !== 32'h100) begin
      n_err++; $display("FAIL ct_at_m: flags=%b pcM=%h want 1100000 00000100", flags, pcM);
    end
    step();
    n_cmp++;
    if (branch_cnt !== 4'd1 || mispred_cnt !== 4'd0 || flags !== 7'b0) begin
      n_err++;
      $display("FAIL ct_after: bc=%0d mc=%0d flags=%b want 1 0 0000000", branch_cnt, mispred_cnt, flags);
    end
  endtask

  task automatic test_mispredict_nt_t();
    do_reset();
    send(1'b0, 32'h400, 32'h480);
    step();
    idle(); actual_takeE = 1'b1;
    step();
    idle();
    n_cmp++;
    if (flags !== 7'b1111100 || pcM !== 32'h400) begin
      n_err++; $display("FAIL mp_ntt_m: flags=%b pcM=%h want 1111100 00000400", flags, pcM);
    end
    step();
    n_cmp++;
    if (flags !== 7'b0001111 || redirect_pc !== 32'h480 || mispred_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL mp_ntt_redir: flags=%b rpc=%h mc=%0d want 0001111 00000480 1", flags, redirect_pc, mispred_cnt);
    end
    step();
    n_cmp++;
    if (flags !== 7'b0 || branch_cnt !== 4'd1) begin
      n_err++; $display("FAIL mp_ntt_normal: flags=%b bc=%0d want 0000000 1", flags, branch_cnt);
    end
  endtask

  task automatic test_mispredict_t_nt();
    do_reset();
    send(1'b1, 32'h1000, 32'h2000);
    step();
    idle(); actual_takeE = 1'b0;
    step();
    idle();
    n_cmp++;
    if (flags !== 7'b1011100) begin
      n_err++; $display("FAIL mp_tnt_m: flags=%b want 1011100", flags);
    end
    step();
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1008) begin
      n_err++; $display("FAIL mp_tnt_pc: rv=%b rpc=%h want 1 00001008", redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_handshake();
    do_reset();
    send(1'b0, 32'h300, 32'h340);
    step();
    idle(); actual_takeE = 1'b1;
    step();
    idle(); redirect_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 32'h900 + 32'(i * 4), 32'hA00);
      actual_takeE = 1'b1;
      n_cmp++;
      if (redirect_valid !== 1'b1 || stall_req !== 1'b1 || redirect_pc !== 32'h340) begin
        n_err++;
        $display("FAIL hs_hold%0d: rv=%b stall=%b rpc=%h want 1 1 00000340", i, redirect_valid, stall_req, redirect_pc);
      end
      step();
    end
    redirect_ready = 1'b1;
    n_cmp++;
    if (redirect_valid !== 1'b1 || flushE !== 1'b1) begin
      n_err++; $display("FAIL hs_accept: rv=%b flushE=%b want 1 1", redirect_valid, flushE);
    end
    step();
    idle();
    n_cmp++;
    if (redirect_valid !== 1'b0 || stall_req !== 1'b0) begin
      n_err++; $display("FAIL hs_release: rv=%b stall=%b want 0 0", redirect_valid, stall_req);
    end
    step();
    step();
    n_cmp++;
    if (branchM !== 1'b0 || branch_cnt !== 4'd1 || mispred_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL hs_wrongpath: branchM=%b bc=%0d mc=%0d want 0 1 1", branchM, branch_cnt, mispred_cnt);
    end
  endtask

  task automatic test_stall_once();
    do_reset();
    send(1'b1, 32'h500, 32'h600);
    step();
    idle(); actual_takeE = 1'b1;
    step();
    idle(); pipe_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (branchM !== (i == 0) || pcM !== 32'h500 || errorM !== 1'b0) begin
        n_err++;
        $display("FAIL st_cycle%0d: branchM=%b pcM=%h errorM=%b want %0d 00000500 0", i, branchM, pcM, errorM, (i == 0));
      end
      step();
    end
    pipe_stall = 1'b0;
    step();
    n_cmp++;
    if (branch_cnt !== 4'd1 || branchM !== 1'b0) begin
      n_err++; $display("FAIL st_count: bc=%0d branchM=%b want 1 0", branch_cnt, branchM);
    end
  endtask

  task automatic test_error_with_stall();
    do_reset();
    send(1'b0, 32'h600, 32'h640);
    step();
    send(1'b1, 32'h700, 32'h800);
    actual_takeE = 1'b1;
    step();
    idle(); pipe_stall = 1'b1;
    n_cmp++;
    if (flags !== 7'b1111100) begin
      n_err++; $display("FAIL es_flush: flags=%b want 1111100", flags);
    end
    step();
    idle();
    n_cmp++;
    if ({branchM, errorM, redirect_valid, stall_req} !== 4'b0011 || redirect_pc !== 32'h640) begin
      n_err++;
      $display("FAIL es_redir: bM/eM/rv/st=%b%b%b%b rpc=%h want 0011 00000640", branchM, errorM, redirect_valid, stall_req, redirect_pc);
    end
    step();
    step();
    n_cmp++;
    if (branchM !== 1'b0 || branch_cnt !== 4'd1 || mispred_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL es_killed: branchM=%b bc=%0d mc=%0d want 0 1 1", branchM, branch_cnt, mispred_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(1'b0, 32'h2000 + 32'(i * 16), 32'h3000);
      step();
      idle(); actual_takeE = 1'b1;
      step();
      idle();
      step();
      step();
      if (i == 13) begin
        n_cmp++;
        if (mispred_cnt !== 4'd14) begin
          n_err++; $display("FAIL sat_pre: mc=%0d want 14", mispred_cnt);
        end
      end
    end
    n_cmp++;
    if (mispred_cnt !== 4'hF || branch_cnt !== 4'hF) begin
      n_err++; $display("FAIL sat_hold: mc=%0d bc=%0d want 15 15", mispred_cnt, branch_cnt);
    end
  endtask

  task automatic test_reset_in_redirect();
    do_reset();
    send(1'b0, 32'h40, 32'h80);
    step();
    idle(); actual_takeE = 1'b1;
    step();
    idle(); redirect_ready = 1'b0;
    step();
    n_cmp++;
    if (redirect_valid !== 1'b1) begin
      n_err++; $display("FAIL rr_enter: rv=%b want 1", redirect_valid);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (flags !== 7'b0 || redirect_pc !== 32'h0 || pcM !== 32'h0 ||
        branch_cnt !== 4'd0 || mispred_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL rr_cleared: flags=%b rpc=%h pcM=%h bc=%0d mc=%0d want all 0", flags, redirect_pc, pcM, branch_cnt, mispred_cnt);
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_correct_taken();
    test_mispredict_nt_t();
    test_mispredict_t_nt();
    test_handshake();
    test_stall_once();
    test_error_with_stall();
    test_saturation();
    test_reset_in_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
